ks28_add_sched: RTL

//  Round-robin scheduler sharing one combinational 28-bit Kogge-Stone adder between two

---
 rtl/ks28_add_sched.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ks28_add_sched.sv
// ks28_add_sched: round-robin scheduler sharing one external combinational
// W-bit adder between two requesters. Two stages: S1 operand register
// drives the adder, and S2 captures sum/carry with the requester tag.
module ks28_add_sched #(
    parameter int unsigned W       = 28,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_sum,
    input  logic         add_cout,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         res_tag,
    output logic         busy
);

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_e;

    // Stage 1: operand register feeding the adder
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_a_q,     s1_a_d;
    logic [W-1:0] s1_b_q,     s1_b_d;
    logic         s1_cin_q,   s1_cin_d;
    req_idx_e     s1_tag_q,   s1_tag_d;

    // Stage 2: result register
    logic         res_valid_q, res_valid_d;
    logic [W-1:0] res_sum_q,   res_sum_d;
    logic         res_cout_q,  res_cout_d;
    req_idx_e     res_tag_q,   res_tag_d;

    // Priority pointer: requester favoured when both are valid
    req_idx_e     ptr_q, ptr_d;

    logic         s2_adv;
    logic         s1_adv;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [W-1:0] win_a;
    logic [W-1:0] win_b;
    logic         win_sub;

    // Handshake, arbitration and winner operand selection
    always_comb begin
        s2_adv     = !res_valid_q || res_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        grant0     = req0_valid && (!req1_valid || (ptr_q == REQ0));
        grant1     = req1_valid && (!req0_valid || (ptr_q == REQ1));
        // Readies are forced low while reset is asserted, since the empty
        // pipeline would otherwise advertise space.
        req0_ready = grant0 && s1_adv && rst_n;
        req1_ready = grant1 && s1_adv && rst_n;
        accept     = req0_ready || req1_ready;
        win_a      = grant1 ? req1_a   : req0_a;
        win_b      = grant1 ? req1_b   : req0_b;
        win_sub    = grant1 ? req1_sub : req0_sub;
    end

    // Next-state for both pipeline stages and the priority pointer
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        s1_tag_d    = s1_tag_q;
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_tag_d   = res_tag_q;

        if (s1_adv) begin
            s1_valid_d = accept;
            // Operands only change on accept, so add_* stay quiet during bubbles.
            if (accept) begin
                s1_a_d   = win_a;
                s1_b_d   = win_sub ? ~win_b : win_b;
                s1_cin_d = win_sub;
                s1_tag_d = grant1 ? REQ1 : REQ0;
                ptr_d    = grant1 ? REQ0 : REQ1;
            end
        end

        if (s2_adv) begin
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_sum_d  = add_sum;
                res_cout_d = add_cout;
                res_tag_d  = s1_tag_q;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_tag_q    <= REQ0;
            ptr_q       <= RR_INIT ? REQ1 : REQ0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_tag_q   <= REQ0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s1_tag_q    <= s1_tag_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign add_a     = s1_a_q;
    assign add_b     = s1_b_q;
    assign add_cin   = s1_cin_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_tag   = res_tag_q;
    assign busy      = s1_valid_q || res_valid_q;

endmodule
